// File: rtl/ins_fetch_buffer_if.sv
// Fetch-to-decode instruction queue handshake bundle.
// The buffer takes the slave view; the fetch/decode side drives the master view.
interface ins_fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            FLUSH;
    logic            IN_VALID;
    logic            IN_READY;
    logic [31:0]     IN_INS;
    logic [XLEN-1:0] IN_PC;
    logic            IN_FAULT;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [31:0]     OUT_INS;
    logic [XLEN-1:0] OUT_PC;
    logic            OUT_FAULT;
    logic [CW-1:0]   COUNT;

    modport slave (
        input  FLUSH, IN_VALID, IN_INS, IN_PC, IN_FAULT, OUT_READY,
        output IN_READY, OUT_VALID, OUT_INS, OUT_PC, OUT_FAULT, COUNT
    );

    modport master (
        output FLUSH, IN_VALID, IN_INS, IN_PC, IN_FAULT, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_INS, OUT_PC, OUT_FAULT, COUNT
    );
endinterface

// File: rtl/ins_fetch_buffer.sv
// Circular instruction queue between fetch and decode with first-word-fall-through head.
// Optional macro FETCH_BYPASS_EN adds a zero-latency IN-to-OUT path when the queue is empty.
module ins_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                CLK,
    input  logic                RST,
    ins_fetch_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]     mem_ins_q   [DEPTH];
    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic            mem_fault_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic bypass;
    logic in_ready, out_valid;
    logic push, pop;

`ifdef FETCH_BYPASS_EN
    assign bypass = !RST && !bus.FLUSH && bus.IN_VALID && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = !RST && !bus.FLUSH && (count_q < CW'(DEPTH));
    assign out_valid = !RST && !bus.FLUSH && ((count_q != '0) || bypass);

    // A bypassed instruction that decode takes immediately is never written.
    assign push = bus.IN_VALID && in_ready && !(bypass && bus.OUT_READY);
    assign pop  = out_valid && bus.OUT_READY && !bypass;

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.COUNT     = count_q;

    always_comb begin
        bus.OUT_INS   = NOP;
        bus.OUT_PC    = '0;
        bus.OUT_FAULT = 1'b0;
        if (out_valid) begin
            if (bypass) begin
                bus.OUT_INS   = bus.IN_INS;
                bus.OUT_PC    = bus.IN_PC;
                bus.OUT_FAULT = bus.IN_FAULT;
            end else begin
                bus.OUT_INS   = mem_ins_q[rd_ptr_q];
                bus.OUT_PC    = mem_pc_q[rd_ptr_q];
                bus.OUT_FAULT = mem_fault_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; output gating hides stale contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_ins_q[wr_ptr_q]   <= bus.IN_INS;
            mem_pc_q[wr_ptr_q]    <= bus.IN_PC;
            mem_fault_q[wr_ptr_q] <= bus.IN_FAULT;
        end
    end
endmodule

// File: tb/tb_ins_fetch_buffer.sv
// Directed-vector bench for ins_fetch_buffer: reset, fill/drain, wrap streaming,
// flush, fault tagging and the empty-queue fast path (with or without FETCH_BYPASS_EN).
module tb_ins_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    ins_fetch_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bif ();

    ins_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic flt, input logic ordy);
        bif.IN_VALID  = v;
        bif.IN_PC     = pc;
        bif.IN_INS    = pc[31:0] ^ 32'hA500_0000;
        bif.IN_FAULT  = flt;
        bif.OUT_READY = ordy;
    endtask

    logic [63:0] exp_pc;
    logic [63:0] nxt_pc;

    initial begin
        RST = 1'b1;
        bif.FLUSH = 1'b0;
        drive(1'b1, 64'hDEAD_0000, 1'b0, 1'b0);

        // Reset held two cycles with fetch presenting an instruction
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_vec("rst_in_ready", 64'(bif.IN_READY), 64'd0);
            check_vec("rst_out_valid", 64'(bif.OUT_VALID), 64'd0);
            check_vec("rst_out_ins", 64'(bif.OUT_INS), 64'(NOP));
            check_vec("rst_out_pc", bif.OUT_PC, 64'd0);
            check_vec("rst_count", 64'(bif.COUNT), 64'd0);
        end
        RST = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        check_vec("post_rst_count", 64'(bif.COUNT), 64'd0);
        check_vec("post_rst_valid", 64'(bif.OUT_VALID), 64'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 1'b0);
            #1;
            check_vec("fill_in_ready", 64'(bif.IN_READY), 64'd1);
            cyc();
        end
        drive(1'b1, 64'h1010, 1'b0, 1'b0);
        #1;
        check_vec("full_count", 64'(bif.COUNT), 64'd4);
        check_vec("full_in_ready", 64'(bif.IN_READY), 64'd0);
        cyc();
        check_vec("full_held_count", 64'(bif.COUNT), 64'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'd0, 1'b0, 1'b1);
            #1;
            check_vec("drain_valid", 64'(bif.OUT_VALID), 64'd1);
            check_vec("drain_pc", bif.OUT_PC, 64'h1000 + 64'(4 * i));
            check_vec("drain_ins", 64'(bif.OUT_INS), 64'(32'hA500_1000 + 32'(4 * i)));
            cyc();
        end
        check_vec("empty_valid", 64'(bif.OUT_VALID), 64'd0);
        check_vec("empty_count", 64'(bif.COUNT), 64'd0);
        check_vec("empty_ins", 64'(bif.OUT_INS), 64'(NOP));

        // Streaming at occupancy 2 across several pointer wraps
        drive(1'b1, 64'h6000, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'h6004, 1'b0, 1'b0); cyc();
        nxt_pc = 64'h6008;
        exp_pc = 64'h6000;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, nxt_pc, 1'b0, 1'b1);
            #1;
            check_vec("stream_pc", bif.OUT_PC, exp_pc);
            check_vec("stream_count", 64'(bif.COUNT), 64'd2);
            cyc();
            nxt_pc += 64'd4;
            exp_pc += 64'd4;
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 64'd0, 1'b0, 1'b1);
            #1;
            check_vec("stream_tail_pc", bif.OUT_PC, exp_pc);
            cyc();
            exp_pc += 64'd4;
        end
        check_vec("stream_end_count", 64'(bif.COUNT), 64'd0);

        // Flush with push and pop requested in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h7000 + 64'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        check_vec("preflush_count", 64'(bif.COUNT), 64'd3);
        bif.FLUSH = 1'b1;
        drive(1'b1, 64'h2000, 1'b0, 1'b1);
        #1;
        check_vec("flush_in_ready", 64'(bif.IN_READY), 64'd0);
        check_vec("flush_out_valid", 64'(bif.OUT_VALID), 64'd0);
        cyc();
        bif.FLUSH = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check_vec("postflush_count", 64'(bif.COUNT), 64'd0);
        check_vec("postflush_valid", 64'(bif.OUT_VALID), 64'd0);
        drive(1'b1, 64'h3000, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check_vec("postflush_pc", bif.OUT_PC, 64'h3000);
        check_vec("postflush_cnt1", 64'(bif.COUNT), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        cyc();
        check_vec("postflush_drained", 64'(bif.COUNT), 64'd0);

        // Fault flag travels with its own PC
        drive(1'b1, 64'h3FFC, 1'b0, 1'b0); cyc();
        drive(1'b1, 64'h4000, 1'b1, 1'b0); cyc();
        drive(1'b1, 64'h4004, 1'b0, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'd0, 1'b0, 1'b1);
            #1;
            check_vec("fault_pc", bif.OUT_PC, 64'h3FFC + 64'(4 * i));
            check_vec("fault_flag", 64'(bif.OUT_FAULT), (i == 1) ? 64'd1 : 64'd0);
            cyc();
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        #1;
        check_vec("fault_empty", 64'(bif.OUT_FAULT), 64'd0);

        // Empty-queue fast path
        drive(1'b1, 64'h5000, 1'b0, 1'b1);
        #1;
`ifdef FETCH_BYPASS_EN
        check_vec("byp_valid", 64'(bif.OUT_VALID), 64'd1);
        check_vec("byp_pc", bif.OUT_PC, 64'h5000);
        cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        #1;
        check_vec("byp_count", 64'(bif.COUNT), 64'd0);
        check_vec("byp_after_valid", 64'(bif.OUT_VALID), 64'd0);
`else
        check_vec("nobyp_valid", 64'(bif.OUT_VALID), 64'd0);
        cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        #1;
        check_vec("nobyp_next_valid", 64'(bif.OUT_VALID), 64'd1);
        check_vec("nobyp_next_pc", bif.OUT_PC, 64'h5000);
        cyc();
        check_vec("nobyp_count", 64'(bif.COUNT), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ins_fetch_buffer.md
Name: ins_fetch_buffer

Overview:
Instruction queue between the I-cache/fetch stage and the decode stage. It holds fetched 32-bit instructions with their PC and fetch-fault flag, and presents the oldest one to the decode control logic. It decouples fetch from decode stalls and is cleared on any pipeline redirect (branch, jump, trap, fence).

Parameters:
DEPTH, 4, number of entries; power of two, at least 2.
XLEN, 64, PC width.

Ports:
CLK  input  1  clock
RST  input  1  reset
FLUSH  input  1  redirect; discard all entries
IN_VALID  input  1  fetch presents an instruction
IN_READY  output  1  buffer accepts this cycle
IN_INS  input  32  fetched instruction word
IN_PC  input  XLEN  PC of IN_INS
IN_FAULT  input  1  fetch access or page fault for IN_PC
OUT_VALID  output  1  head entry valid to decode
OUT_READY  input  1  decode consumes head this cycle
OUT_INS  output  32  head instruction; 32'h00000013 (NOP) when not valid
OUT_PC  output  XLEN  head PC; 0 when not valid
OUT_FAULT  output  1  head fault flag; 0 when not valid
COUNT  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- One clock domain, CLK.
- RST is synchronous and active-high.
- While RST is high or in the cycle after RST deasserts:
  - Pointers and count are 0.
  - IN_READY=0 while RST=1.
  - OUT_VALID=0, OUT_INS=NOP, OUT_PC=0, OUT_FAULT=0, COUNT=0.
- Storage is a circular array indexed by wr_ptr/rd_ptr of $clog2(DEPTH) bits.
  - Pointers wrap from DEPTH-1 to 0 by natural overflow.
  - The count register is $clog2(DEPTH)+1 bits.
- push = IN_VALID & IN_READY.
  - IN_READY = !RST & !FLUSH & (COUNT < DEPTH).
  - IN_READY does not depend on OUT_READY: there is no push into a full buffer even if a pop happens in the same cycle.
- pop = OUT_VALID & OUT_READY.
  - OUT_VALID = !FLUSH & (COUNT != 0).
  - Outputs are combinational reads of the head entry (first-word-fall-through from registered storage).
- Latency: an instruction pushed in cycle N is visible on OUT in cycle N+1 at the earliest.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- Boundaries:
  - Empty: pop is impossible.
  - Full (COUNT==DEPTH): IN_READY=0.
  - Wrap: entry order is preserved across the pointer wrap.
- FLUSH (one or more cycles):
  - No push and no pop in that cycle.
  - Next cycle: wr_ptr=rd_ptr=0, COUNT=0.
  - Takes priority over everything except RST.
- FLUSH and RST together: reset behaviour.
- Each entry stores INS, PC and FAULT together. The fault flag travels with its PC, so decode can raise the instruction fault in order.
- Entry storage has no reset requirement; only pointers and count are reset. The output gating above hides stale data.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when COUNT==0, IN_VALID=1, FLUSH=0 and RST=0:
  - OUT_VALID=1 and OUT_INS/OUT_PC/OUT_FAULT = IN_* combinationally (zero latency).
  - If OUT_READY=1, the instruction is consumed and not written; COUNT stays 0.
  - If OUT_READY=0, it is written normally (IN_READY=1) and appears from storage next cycle.
- Undefined: no combinational IN-to-OUT path; minimum latency is 1 cycle as above.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, OUT_INS=32'h00000013, COUNT=0; no entry captured.
- Fill/drain: push PCs 0x1000, 0x1004, 0x1008, 0x100C with OUT_READY=0 -> COUNT=4, IN_READY=0. Fifth instruction held upstream. Then OUT_READY=1 -> four entries appear in PC order, one per cycle, then OUT_VALID=0.
- Wrap and streaming: hold COUNT=2 with push and pop every cycle for 10 cycles -> COUNT stays 2, output PCs strictly increase by 4, no loss across pointer wrap.
- Flush: three entries queued; assert FLUSH together with IN_VALID (PC 0x2000) and OUT_READY -> no pop and no push that cycle; next cycle COUNT=0, OUT_VALID=0. Push PC 0x3000 -> it is the next OUT_PC.
- Fault tag: push PC 0x4000 with IN_FAULT=1 between two clean instructions -> OUT_FAULT=1 only while OUT_PC=0x4000.
- Bypass (FETCH_BYPASS_EN): empty buffer, IN_VALID=1 with PC 0x5000, OUT_READY=1 -> OUT_VALID=1 and OUT_PC=0x5000 in the same cycle; COUNT remains 0. Without the macro -> OUT_VALID=0 that cycle and PC 0x5000 appears the next cycle.
